// File: rtl/bfu_pipe_if.sv
// Stream interface for bfu_pipe: input item channel, output result channel and status.
// The master side feeds items and consumes results; the slave side is the butterfly.
interface bfu_pipe_if #(
  parameter int DATA_WIDTH = 12,
  parameter int TAG_WIDTH  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] u;
  logic [DATA_WIDTH-1:0] v;
  logic [DATA_WIDTH-1:0] w;
  logic [TAG_WIDTH-1:0]  tag_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] bf_upper;
  logic [DATA_WIDTH-1:0] bf_lower;
  logic [TAG_WIDTH-1:0]  tag_out;
  logic                  busy;

  modport master (
    output in_valid, mode, u, v, w, tag_in, out_ready,
    input  in_ready, out_valid, bf_upper, bf_lower, tag_out, busy
  );

  modport slave (
    input  in_valid, mode, u, v, w, tag_in, out_ready,
    output in_ready, out_valid, bf_upper, bf_lower, tag_out, busy
  );
endinterface

// File: rtl/bfu_pipe.sv
// bfu_pipe: fully pipelined modular butterfly (CT / GS / MUL / BYPASS) with valid/ready and tag.
// Define BFU_GS_HALF_EN to halve both GS results (folds the INTT 1/2-per-layer scaling in).
module bfu_pipe #(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int MUL_LAT    = 4,
  parameter int TAG_WIDTH  = 8
) (
  input  logic      clk,
  input  logic      rst,
  bfu_pipe_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW;
  localparam int BW = 2 * PW + 1;
  localparam logic [DW:0]   QE = (DW + 1)'(Q);
  localparam logic [PW-1:0] QP = PW'(Q);
  // Barrett constant floor(2^PW / Q); any product < 2^PW lands within 2Q of the true residue.
  localparam logic [BW-1:0] BM = BW'((64'd1 << PW) / 64'(Q));

  localparam logic [1:0] M_CT  = 2'b00;
  localparam logic [1:0] M_GS  = 2'b01;
  localparam logic [1:0] M_MUL = 2'b10;

  typedef struct packed {
    logic                 vld;
    logic [1:0]           mode;
    logic [TAG_WIDTH-1:0] tag;
    logic [DW-1:0]        u;
    logic [DW-1:0]        v;
    logic [DW-1:0]        w;
  } in_t;

  typedef struct packed {
    logic                 vld;
    logic [1:0]           mode;
    logic [TAG_WIDTH-1:0] tag;
    logic [DW-1:0]        a;
    logic [DW-1:0]        b;
  } side_t;

  function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QE) s = s - QE;
    return s[DW-1:0];
  endfunction

  // Wrapping in DW bits is exact here because the true result is always in [0, Q).
  function automatic logic [DW-1:0] sub_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return (x < y) ? (x - y + DW'(Q)) : (x - y);
  endfunction

  function automatic logic [DW-1:0] mod_reduce(input logic [PW-1:0] p);
    logic [PW-1:0] qh;
    logic [PW-1:0] r;
    qh = PW'((BW'(p) * BM) >> PW);
    r  = p - qh * QP;
    if (r >= QP) r = r - QP;
    if (r >= QP) r = r - QP;
    return r[DW-1:0];
  endfunction

`ifdef BFU_GS_HALF_EN
  function automatic logic [DW-1:0] half_mod(input logic [DW-1:0] x);
    return DW'(({1'b0, x} + (x[0] ? QE : '0)) >> 1);
  endfunction
`endif

  in_t                  s0_q, s0_d;
  side_t                side_q [MUL_LAT];
  side_t                side_d [MUL_LAT];
  side_t                last;
  logic                 out_vld_q, out_vld_d;
  logic [DW-1:0]        up_q, up_d, lo_q, lo_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 adv;
  logic                 busy_w;
  logic [DW-1:0]        mul_a, mul_b, mul_res, side_a;

  // Whole-pipeline enable: every stage, multiplier internals included, moves or holds together.
  assign adv  = !out_vld_q || bus.out_ready;
  assign last = side_q[MUL_LAT-1];

  always_comb begin
    s0_d = s0_q;
    if (adv) begin
      s0_d.vld  = bus.in_valid;
      s0_d.mode = bus.mode;
      s0_d.tag  = bus.tag_in;
      s0_d.u    = bus.u;
      s0_d.v    = bus.v;
      s0_d.w    = bus.w;
    end
  end

  assign mul_b = s0_q.w;

  always_comb begin
    mul_a  = s0_q.u;
    side_a = s0_q.u;
    case (s0_q.mode)
      M_CT: mul_a = s0_q.v;
      M_GS: begin
        mul_a  = sub_mod(s0_q.u, s0_q.v);
        side_a = add_mod(s0_q.u, s0_q.v);
      end
      default: ;
    endcase
  end

  always_comb begin
    side_d = side_q;
    if (adv) begin
      side_d[0] = '{vld: s0_q.vld, mode: s0_q.mode, tag: s0_q.tag, a: side_a, b: s0_q.v};
      for (int i = 1; i < MUL_LAT; i++) side_d[i] = side_q[i-1];
    end
  end

  generate
    if (MUL_LAT == 1) begin : g_mul_single
      logic [DW-1:0] m_q, m_d;
      always_comb m_d = adv ? mod_reduce(PW'(mul_a) * PW'(mul_b)) : m_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) m_q <= '0;
        else      m_q <= m_d;
      end
      assign mul_res = m_q;
    end else begin : g_mul_multi
      // Stage 1 holds the raw product, stage 2 the reduced residue, the rest only delay it.
      logic [PW-1:0] prod_q, prod_d;
      logic [DW-1:0] red_q [MUL_LAT-1];
      logic [DW-1:0] red_d [MUL_LAT-1];
      always_comb begin
        prod_d = prod_q;
        red_d  = red_q;
        if (adv) begin
          prod_d   = PW'(mul_a) * PW'(mul_b);
          red_d[0] = mod_reduce(prod_q);
          for (int i = 1; i < MUL_LAT - 1; i++) red_d[i] = red_q[i-1];
        end
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          prod_q <= '0;
          for (int i = 0; i < MUL_LAT - 1; i++) red_q[i] <= '0;
        end else begin
          prod_q <= prod_d;
          red_q  <= red_d;
        end
      end
      assign mul_res = red_q[MUL_LAT-2];
    end
  endgenerate

  always_comb begin
    out_vld_d = out_vld_q;
    up_d      = up_q;
    lo_d      = lo_q;
    tag_d     = tag_q;
    if (adv) begin
      out_vld_d = last.vld;
      tag_d     = last.tag;
      case (last.mode)
        M_CT: begin
          up_d = add_mod(last.a, mul_res);
          lo_d = sub_mod(last.a, mul_res);
        end
        M_GS: begin
`ifdef BFU_GS_HALF_EN
          up_d = half_mod(last.a);
          lo_d = half_mod(mul_res);
`else
          up_d = last.a;
          lo_d = mul_res;
`endif
        end
        M_MUL: begin
          up_d = mul_res;
          lo_d = last.b;
        end
        default: begin
          up_d = last.a;
          lo_d = last.b;
        end
      endcase
    end
  end

  always_comb begin
    busy_w = s0_q.vld | out_vld_q;
    for (int i = 0; i < MUL_LAT; i++) busy_w = busy_w | side_q[i].vld;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) side_q[i] <= '0;
      out_vld_q <= 1'b0;
      up_q      <= '0;
      lo_q      <= '0;
      tag_q     <= '0;
    end else begin
      s0_q      <= s0_d;
      side_q    <= side_d;
      out_vld_q <= out_vld_d;
      up_q      <= up_d;
      lo_q      <= lo_d;
      tag_q     <= tag_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_vld_q;
  assign bus.bf_upper  = up_q;
  assign bus.bf_lower  = lo_q;
  assign bus.tag_out   = tag_q;
  assign bus.busy      = busy_w;
endmodule

// File: tb/tb_bfu_pipe.sv
// Self-checking bench for bfu_pipe: directed butterflies, stall/back-to-back stream,
// mid-stream reset and a random scoreboard run against an integer reference model.
module tb_bfu_pipe;
  localparam int DW      = 12;
  localparam int Q       = 3329;
  localparam int MUL_LAT = 4;
  localparam int TW      = 8;
  localparam int LAT     = MUL_LAT + 2;
  localparam int NRAND   = 10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bfu_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();
  bfu_pipe #(.DATA_WIDTH(DW), .Q(Q), .MUL_LAT(MUL_LAT), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  typedef struct {
    int up;
    int lo;
    int tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef BFU_GS_HALF_EN
  function automatic int half_ref(input int x);
    return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
  endfunction
`endif

  function automatic exp_t model(input int m, input int u, input int v, input int w, input int t);
    exp_t e;
    int   p;
    e.tag = t;
    case (m)
      0: begin
        p    = (v * w) % Q;
        e.up = (u + p) % Q;
        e.lo = (u - p + Q) % Q;
      end
      1: begin
        p = (((u - v + Q) % Q) * w) % Q;
`ifdef BFU_GS_HALF_EN
        e.up = half_ref((u + v) % Q);
        e.lo = half_ref(p);
`else
        e.up = (u + v) % Q;
        e.lo = p;
`endif
      end
      2: begin
        e.up = (u * w) % Q;
        e.lo = v;
      end
      default: begin
        e.up = u;
        e.lo = v;
      end
    endcase
    return e;
  endfunction

  task automatic drive(input int m, input int u, input int v, input int w, input int t);
    bus.mode     = 2'(m);
    bus.u        = DW'(u);
    bus.v        = DW'(v);
    bus.w        = DW'(w);
    bus.tag_in   = TW'(t);
    bus.in_valid = 1'b1;
  endtask

  // Sends one item into an idle pipe and returns cycles-to-output (-1 on timeout) and the result.
  task automatic send_one(input int m, input int u, input int v, input int w, input int t,
                          output int lat, output int up, output int lo, output int tg);
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(m, u, v, w, t);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.out_valid) lat = -1;
    up = int'(bus.bf_upper);
    lo = int'(bus.bf_lower);
    tg = int'(bus.tag_out);
    $display("item mode=%0d u=%0d v=%0d w=%0d tag=%0d -> upper=%0d lower=%0d tag=%0d lat=%0d",
             m, u, v, w, t, up, lo, tg, lat);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.bf_upper !== '0 || bus.bf_lower !== '0 || bus.tag_out !== '0) begin
      errors++; $display("FAIL rst_data got %0d/%0d/%0d want 0/0/0", bus.bf_upper, bus.bf_lower, bus.tag_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ct();
    int lat, up, lo, tg;
    send_one(0, 1, 2, 1729, 8'h3c, lat, up, lo, tg);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL ct_latency got %0d want %0d", lat, LAT); end
    checks++; if (up !== 130 || lo !== 3201) begin errors++; $display("FAIL ct_result got %0d/%0d want 130/3201", up, lo); end
    checks++; if (tg !== 8'h3c) begin errors++; $display("FAIL ct_tag got %0d want %0d", tg, 8'h3c); end
  endtask

  task automatic test_gs();
    int lat, up, lo, tg;
    int e_up, e_lo, o_up, o_lo;
`ifdef BFU_GS_HALF_EN
    e_up = 4;    e_lo = 17;
    o_up = 1665; o_lo = 1665;
`else
    e_up = 8;    e_lo = 34;
    o_up = 1;    o_lo = 1;
`endif
    send_one(1, 5, 3, 17, 21, lat, up, lo, tg);
    checks++; if (up !== e_up || lo !== e_lo || tg !== 21) begin
      errors++; $display("FAIL gs_result got %0d/%0d tag %0d want %0d/%0d tag 21", up, lo, tg, e_up, e_lo);
    end
    send_one(1, 1, 0, 1, 22, lat, up, lo, tg);
    checks++; if (up !== o_up || lo !== o_lo) begin
      errors++; $display("FAIL gs_odd got %0d/%0d want %0d/%0d", up, lo, o_up, o_lo);
    end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL gs_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_mul_bypass();
    int lat, up, lo, tg;
    send_one(2, 3328, 77, 3328, 5, lat, up, lo, tg);
    checks++; if (up !== 1 || lo !== 77) begin errors++; $display("FAIL mul_result got %0d/%0d want 1/77", up, lo); end
    send_one(3, 10, 20, 999, 6, lat, up, lo, tg);
    checks++; if (up !== 10 || lo !== 20 || tg !== 6) begin
      errors++; $display("FAIL bypass_result got %0d/%0d tag %0d want 10/20 tag 6", up, lo, tg);
    end
  endtask

  // 12 items with rotating modes, out_ready dropped for 3 cycles after the first output.
  task automatic test_back_to_back();
    int   n_in = 0, got = 0, cyc = 0, stall_left = 0;
    logic rdy, first_stall = 1'b1;
    logic [DW-1:0] snap_up, snap_lo;
    logic [TW-1:0] snap_tg;
    exp_t e;
    while (got < 12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      rdy = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      bus.out_ready = rdy;
      #1;
      if (!rdy) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", bus.in_ready); end
        if (first_stall) begin
          snap_up = bus.bf_upper; snap_lo = bus.bf_lower; snap_tg = bus.tag_out;
          first_stall = 1'b0;
        end else begin
          checks++; if (bus.bf_upper !== snap_up || bus.bf_lower !== snap_lo || bus.tag_out !== snap_tg) begin
            errors++; $display("FAIL stall_hold got %0d/%0d/%0d want %0d/%0d/%0d",
                               bus.bf_upper, bus.bf_lower, bus.tag_out, snap_up, snap_lo, snap_tg);
          end
        end
      end
      if (bus.out_valid && rdy) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL stream_extra got tag %0d want no output", bus.tag_out);
        end else begin
          e = sb.pop_front();
          checks++; if (bus.bf_upper !== e.up || bus.bf_lower !== e.lo || bus.tag_out !== e.tag) begin
            errors++; $display("FAIL stream_item got %0d/%0d tag %0d want %0d/%0d tag %0d",
                               bus.bf_upper, bus.bf_lower, bus.tag_out, e.up, e.lo, e.tag);
          end
          $display("stream out tag=%0d upper=%0d lower=%0d", bus.tag_out, bus.bf_upper, bus.bf_lower);
        end
        if (got == 0) stall_left = 3;
        got++;
      end
      if (n_in < 12) begin
        drive(n_in % 4, (n_in * 271 + 5) % Q, (n_in * 1013 + 7) % Q, (n_in * 97 + 1729) % Q, n_in);
        if (bus.in_ready) begin
          sb.push_back(model(n_in % 4, (n_in * 271 + 5) % Q, (n_in * 1013 + 7) % Q,
                             (n_in * 97 + 1729) % Q, n_in));
          n_in++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got !== 12 || sb.size() !== 0) begin
      errors++; $display("FAIL stream_count got %0d outputs want 12 (pending %0d)", got, sb.size());
    end
  endtask

  task automatic test_midstream_reset();
    int lat, up, lo, tg;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(i % 4, 100 + i, 200 + i, 300 + i, 8'h40 + i);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flush got busy %b valid %b want 0 0", bus.busy, bus.out_valid);
    end
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hold got busy %b in_ready %b want 0 1", bus.busy, bus.in_ready);
    end
    rst_n = 1'b1;
    send_one(0, 7, 9, 100, 8'ha5, lat, up, lo, tg);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL post_reset_latency got %0d want %0d", lat, LAT); end
    checks++; if (up !== 907 || lo !== 2436 || tg !== 8'ha5) begin
      errors++; $display("FAIL post_reset_item got %0d/%0d tag %0d want 907/2436 tag %0d", up, lo, tg, 8'ha5);
    end
  endtask

  task automatic test_random();
    int   n_in = 0, got = 0, cyc = 0;
    int   cm, cu, cv, cw, ct;
    logic rdy;
    exp_t e;
    cm = $urandom_range(0, 3); cu = $urandom_range(0, Q - 1); cv = $urandom_range(0, Q - 1);
    cw = $urandom_range(0, Q - 1); ct = $urandom_range(0, 255);
    while (got < NRAND && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      rdy = ($urandom_range(0, 3) != 0);
      bus.out_ready = rdy;
      #1;
      if (bus.out_valid && rdy) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL rand_extra got tag %0d want no output", bus.tag_out);
        end else begin
          e = sb.pop_front();
          checks++;
          if (bus.bf_upper !== e.up || bus.bf_lower !== e.lo || bus.tag_out !== e.tag ||
              bus.bf_upper >= Q || bus.bf_lower >= Q) begin
            errors++; $display("FAIL rand_item got %0d/%0d tag %0d want %0d/%0d tag %0d",
                               bus.bf_upper, bus.bf_lower, bus.tag_out, e.up, e.lo, e.tag);
          end
        end
        got++;
      end
      if (n_in < NRAND) begin
        drive(cm, cu, cv, cw, ct);
        if (bus.in_ready) begin
          sb.push_back(model(cm, cu, cv, cw, ct));
          n_in++;
          cm = $urandom_range(0, 3); cu = $urandom_range(0, Q - 1); cv = $urandom_range(0, Q - 1);
          cw = $urandom_range(0, Q - 1); ct = $urandom_range(0, 255);
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got !== NRAND || sb.size() !== 0) begin
      errors++; $display("FAIL rand_count got %0d outputs want %0d (pending %0d)", got, NRAND, sb.size());
    end
    $display("random run: %0d items in %0d cycles", got, cyc);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.mode      = 2'b00;
    bus.u         = '0;
    bus.v         = '0;
    bus.w         = '0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_ct();
    test_gs();
    test_mul_bypass();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
